// File: rtl/game_pkg.sv
// Shared game definitions: phase encoding, default frame/lives/level constants
// and the phase-flag decode used by the sequencer.
package game_pkg;

  typedef enum logic [1:0] {
    ST_MENU,
    ST_PLAYING,
    ST_CONTINUE,
    ST_FINAL
  } game_state_e;

  localparam int DEF_LIVES_INIT      = 3;
  localparam int DEF_LEVELS          = 4;
  localparam int DEF_CONTINUE_FRAMES = 180;
  localparam int DEF_FINAL_FRAMES    = 300;

  // Bit order matches the flag outputs: menu, playing, continue, final.
  typedef struct packed {
    logic menu;
    logic playing;
    logic cont;
    logic fin;
  } phase_flags_t;

  function automatic phase_flags_t decode_phase(input game_state_e s);
    phase_flags_t f;
    f = '0;
    case (s)
      ST_MENU:     f.menu    = 1'b1;
      ST_PLAYING:  f.playing = 1'b1;
      ST_CONTINUE: f.cont    = 1'b1;
      ST_FINAL:    f.fin     = 1'b1;
      default:     f.menu    = 1'b1;
    endcase
    return f;
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/game_state_fsm_rising_edge_detect.sv
// Rising-edge detector: one history flop plus AND. RESET_VAL=1 suppresses a
// spurious edge for a level that is already high when reset releases.
module rising_edge_detect #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic sig_i,
  output logic edge_o
);

  logic sig_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sig_q <= RESET_VAL;
    end else begin
      sig_q <= sig_i;
    end
  end

  assign edge_o = sig_i & ~sig_q;

endmodule

// File: rtl/game_state_fsm.sv
// Top-level game sequencer: phase, lives, level and timed-screen countdown,
// all outputs registered; state_o exposes the phase register for debug.
module game_state_fsm
  import game_pkg::*;
#(
  parameter int LIVES_INIT      = DEF_LIVES_INIT,
  parameter int LEVELS          = DEF_LEVELS,
  parameter int CONTINUE_FRAMES = DEF_CONTINUE_FRAMES,
  parameter int FINAL_FRAMES    = DEF_FINAL_FRAMES,
  localparam int LIVES_W = $clog2(LIVES_INIT + 1),
  localparam int LEVEL_W = (LEVELS > 1) ? $clog2(LEVELS) : 1,
  localparam int CNT_W   = $clog2(max_int(CONTINUE_FRAMES, FINAL_FRAMES) + 1)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               frame_tick_i,
  input  logic               start_btn_i,
  input  logic               player_hit_i,
  input  logic               level_clear_i,
  output logic               is_menu_o,
  output logic               is_playing_o,
  output logic               is_continue_o,
  output logic               is_final_o,
  output logic [LIVES_W-1:0] lives_o,
  output logic [LEVEL_W-1:0] level_o,
  output logic               game_won_o,
  output logic [CNT_W-1:0]   countdown_o,
  output logic               restart_level_o,
  output game_state_e        state_o
);

  localparam logic [LIVES_W-1:0] LIVES_LOAD = LIVES_W'(LIVES_INIT);
  localparam logic [LEVEL_W-1:0] LAST_LEVEL = LEVEL_W'(LEVELS - 1);
  localparam logic [CNT_W-1:0]   CONT_LOAD  = CNT_W'(CONTINUE_FRAMES);
  localparam logic [CNT_W-1:0]   FINAL_LOAD = CNT_W'(FINAL_FRAMES);
  localparam logic [CNT_W-1:0]   CNT_ONE    = CNT_W'(1);

  game_state_e state_q;
  game_state_e state_d;
  logic        start_edge;
  logic        last_life;
  logic        last_level;
  logic        timed_exit;

  rising_edge_detect #(
    .RESET_VAL (1'b1)
  ) u_start_edge (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .sig_i  (start_btn_i),
    .edge_o (start_edge)
  );

  // A timed screen ends on the tick that empties the timer or on a start press.
  assign last_life  = (lives_o <= LIVES_W'(1));
  assign last_level = (level_o == LAST_LEVEL);
  assign timed_exit = start_edge | (frame_tick_i & (countdown_o == CNT_ONE));
  assign state_o    = state_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_MENU: begin
        if (start_edge) state_d = ST_PLAYING;
      end
      ST_PLAYING: begin
        if (player_hit_i) begin
          state_d = last_life ? ST_FINAL : ST_CONTINUE;
        end else if (level_clear_i) begin
          state_d = last_level ? ST_FINAL : ST_CONTINUE;
        end
      end
      ST_CONTINUE: begin
        if (timed_exit) state_d = ST_PLAYING;
      end
      ST_FINAL: begin
        if (timed_exit) state_d = ST_MENU;
      end
      default: state_d = ST_MENU;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q         <= ST_MENU;
      is_menu_o       <= 1'b1;
      is_playing_o    <= 1'b0;
      is_continue_o   <= 1'b0;
      is_final_o      <= 1'b0;
      lives_o         <= LIVES_LOAD;
      level_o         <= '0;
      game_won_o      <= 1'b0;
      countdown_o     <= '0;
      restart_level_o <= 1'b0;
    end else begin
      state_q <= state_d;
      {is_menu_o, is_playing_o, is_continue_o, is_final_o} <= decode_phase(state_d);
      restart_level_o <= (state_d == ST_PLAYING) && (state_q != ST_PLAYING);

      case (state_q)
        ST_MENU: begin
          if (start_edge) begin
            lives_o     <= LIVES_LOAD;
            level_o     <= '0;
            game_won_o  <= 1'b0;
            countdown_o <= '0;
          end
        end
        ST_PLAYING: begin
          // A hit in the same cycle as a clear takes priority; the clear is lost.
          if (player_hit_i) begin
            if (last_life) begin
              lives_o     <= '0;
              game_won_o  <= 1'b0;
              countdown_o <= FINAL_LOAD;
            end else begin
              lives_o     <= lives_o - 1'b1;
              countdown_o <= CONT_LOAD;
            end
          end else if (level_clear_i) begin
            if (last_level) begin
              game_won_o  <= 1'b1;
              countdown_o <= FINAL_LOAD;
            end else begin
              level_o     <= level_o + 1'b1;
              countdown_o <= CONT_LOAD;
            end
          end
        end
        ST_CONTINUE, ST_FINAL: begin
          if (timed_exit) begin
            countdown_o <= '0;
          end else if (frame_tick_i && (countdown_o != '0)) begin
            countdown_o <= countdown_o - 1'b1;
          end
        end
        default: countdown_o <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_game_state_fsm.sv
// Directed bench for game_state_fsm: each step pushes its expected output
// vector to exp_q, clocks once, then pops and compares against the DUT.
module tb_game_state_fsm;
  import game_pkg::*;

  localparam int W = 19;
  localparam logic [3:0] P_M = 4'b1000;
  localparam logic [3:0] P_P = 4'b0100;
  localparam logic [3:0] P_C = 4'b0010;
  localparam logic [3:0] P_F = 4'b0001;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        frame_tick_i = 1'b0;
  logic        start_btn_i = 1'b0;
  logic        player_hit_i = 1'b0;
  logic        level_clear_i = 1'b0;
  logic        is_menu_o, is_playing_o, is_continue_o, is_final_o;
  logic [1:0]  lives_o;
  logic [1:0]  level_o;
  logic        game_won_o;
  logic [8:0]  countdown_o;
  logic        restart_level_o;
  game_state_e state_o;

  logic [W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  game_state_fsm dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .frame_tick_i    (frame_tick_i),
    .start_btn_i     (start_btn_i),
    .player_hit_i    (player_hit_i),
    .level_clear_i   (level_clear_i),
    .is_menu_o       (is_menu_o),
    .is_playing_o    (is_playing_o),
    .is_continue_o   (is_continue_o),
    .is_final_o      (is_final_o),
    .lives_o         (lives_o),
    .level_o         (level_o),
    .game_won_o      (game_won_o),
    .countdown_o     (countdown_o),
    .restart_level_o (restart_level_o),
    .state_o         (state_o)
  );

  // clock / reset
  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [W-1:0] pk(input logic [3:0] ph, input logic [1:0] lv,
                                      input logic [1:0] lvl, input logic won,
                                      input int cd, input logic rs);
    return {ph, lv, lvl, won, 9'(cd), rs};
  endfunction

  function automatic logic [W-1:0] observed();
    return {is_menu_o, is_playing_o, is_continue_o, is_final_o, lives_o, level_o,
            game_won_o, countdown_o, restart_level_o};
  endfunction

  // driver + scoreboard compare for one clock
  task automatic step(input string tag, input logic rst, input logic ft, input logic st,
                      input logic hit, input logic clr, input logic [W-1:0] e);
    logic [W-1:0] obs;
    logic [W-1:0] exp_v;
    rst_i         = rst;
    frame_tick_i  = ft;
    start_btn_i   = st;
    player_hit_i  = hit;
    level_clear_i = clr;
    exp_q.push_back(e);
    @(posedge clk_i);
    #1;
    obs   = observed();
    exp_v = exp_q.pop_front();
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  initial begin
    // reset with start held high; release, then press
    step("rst0",      1, 0, 1, 0, 0, pk(P_M, 3, 0, 0, 0, 0));
    step("rst1",      1, 0, 1, 0, 0, pk(P_M, 3, 0, 0, 0, 0));
    step("held",      0, 0, 1, 0, 0, pk(P_M, 3, 0, 0, 0, 0));
    step("release",   0, 0, 0, 0, 0, pk(P_M, 3, 0, 0, 0, 0));
    step("start",     0, 0, 1, 0, 0, pk(P_P, 3, 0, 0, 0, 1));
    step("play",      0, 0, 0, 0, 0, pk(P_P, 3, 0, 0, 0, 0));

    // hit -> continue, full countdown
    step("hit1",      0, 0, 0, 1, 0, pk(P_C, 2, 0, 0, 180, 0));
    step("cont_ign",  0, 0, 0, 1, 1, pk(P_C, 2, 0, 0, 180, 0));
    for (int k = 1; k <= 179; k++)
      step("cont_tick", 0, 1, 0, 0, 0, pk(P_C, 2, 0, 0, 180 - k, 0));
    step("cont_exit", 0, 1, 0, 0, 0, pk(P_P, 2, 0, 0, 0, 1));
    step("play2",     0, 0, 0, 0, 0, pk(P_P, 2, 0, 0, 0, 0));

    // hit, skip with start coincident with a tick
    step("hit2",      0, 0, 0, 1, 0, pk(P_C, 1, 0, 0, 180, 0));
    step("skip_tick", 0, 1, 1, 0, 0, pk(P_P, 1, 0, 0, 0, 1));
    step("rel2",      0, 0, 0, 0, 0, pk(P_P, 1, 0, 0, 0, 0));

    // last life lost -> final (lost), full final countdown
    step("hit3",      0, 0, 0, 1, 0, pk(P_F, 0, 0, 0, 300, 0));
    for (int k = 1; k <= 299; k++)
      step("fin_tick", 0, 1, 0, 0, 0, pk(P_F, 0, 0, 0, 300 - k, 0));
    step("fin_exit",  0, 1, 0, 0, 0, pk(P_M, 0, 0, 0, 0, 0));
    step("menu_ign",  0, 0, 0, 1, 1, pk(P_M, 0, 0, 0, 0, 0));

    // new game, level clears through to a win
    step("start2",    0, 0, 1, 0, 0, pk(P_P, 3, 0, 0, 0, 1));
    step("rel3",      0, 0, 0, 0, 0, pk(P_P, 3, 0, 0, 0, 0));
    step("clear1",    0, 0, 0, 0, 1, pk(P_C, 3, 1, 0, 180, 0));
    step("skip1",     0, 0, 1, 0, 0, pk(P_P, 3, 1, 0, 0, 1));
    step("rel4",      0, 0, 0, 0, 0, pk(P_P, 3, 1, 0, 0, 0));
    step("hit_clr",   0, 0, 0, 1, 1, pk(P_C, 2, 1, 0, 180, 0));
    step("skip2",     0, 1, 1, 0, 0, pk(P_P, 2, 1, 0, 0, 1));
    step("rel5",      0, 0, 0, 0, 0, pk(P_P, 2, 1, 0, 0, 0));
    step("clear2",    0, 0, 0, 0, 1, pk(P_C, 2, 2, 0, 180, 0));
    step("skip3",     0, 0, 1, 0, 0, pk(P_P, 2, 2, 0, 0, 1));
    step("rel6",      0, 0, 0, 0, 0, pk(P_P, 2, 2, 0, 0, 0));
    step("clear3",    0, 0, 0, 0, 1, pk(P_C, 2, 3, 0, 180, 0));
    step("skip4",     0, 0, 1, 0, 0, pk(P_P, 2, 3, 0, 0, 1));
    step("rel7",      0, 0, 0, 0, 0, pk(P_P, 2, 3, 0, 0, 0));
    step("clear_win", 0, 0, 0, 0, 1, pk(P_F, 2, 3, 1, 300, 0));
    step("win_tick",  0, 1, 0, 0, 0, pk(P_F, 2, 3, 1, 299, 0));
    step("win_skip",  0, 0, 1, 0, 0, pk(P_M, 2, 3, 1, 0, 0));
    step("rel8",      0, 0, 0, 0, 0, pk(P_M, 2, 3, 1, 0, 0));

    // reset mid-continue with countdown at 50
    step("start3",    0, 0, 1, 0, 0, pk(P_P, 3, 0, 0, 0, 1));
    step("rel9",      0, 0, 0, 0, 0, pk(P_P, 3, 0, 0, 0, 0));
    step("hit4",      0, 0, 0, 1, 0, pk(P_C, 2, 0, 0, 180, 0));
    for (int k = 1; k <= 130; k++)
      step("cd_to_50", 0, 1, 0, 0, 0, pk(P_C, 2, 0, 0, 180 - k, 0));
    step("rst_mid",   1, 1, 1, 1, 1, pk(P_M, 3, 0, 0, 0, 0));
    step("post_rst",  0, 0, 1, 0, 0, pk(P_M, 3, 0, 0, 0, 0));
    step("rel10",     0, 0, 0, 0, 0, pk(P_M, 3, 0, 0, 0, 0));
    step("start4",    0, 0, 1, 0, 0, pk(P_P, 3, 0, 0, 0, 1));

    // report
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/game_state_fsm.md
# game_state_fsm

Top-level game sequencer: tracks the game phase (menu, playing, continue screen, final screen), lives, level index and the inter-screen countdowns. Produces the one-hot phase flags consumed directly by the `rgb_render` pixel compositor (`is_menu_i`, `is_playing_i`, `is_continue_i`, `is_final_i`). Also produces the lives/level values shown by the number sprite and a restart pulse that reinitialises map, player and enemy logic. All outputs are registered.

## Interface
- `LIVES_INIT`, default 3: lives loaded at game start.
- `LEVELS`, default 4: number of levels; clearing level `LEVELS-1` wins.
- `CONTINUE_FRAMES`, default 180: continue-screen duration in frames.
- `FINAL_FRAMES`, default 300: final-screen duration in frames.

Ports:
- `clk_i`  in  1  pixel clock. Single clock domain.
- `rst_i`  in  1  reset, synchronous, active-high.
- `frame_tick_i`  in  1  one-cycle pulse per video frame (start of vertical blank).
- `start_btn_i`  in  1  start button level, already synchronised to `clk_i`.
- `player_hit_i`  in  1  one-cycle pulse: player tank destroyed.
- `level_clear_i`  in  1  one-cycle pulse: all enemies of the current level destroyed.
- `is_menu_o`, `is_playing_o`, `is_continue_o`, `is_final_o`  out  1 each  one-hot phase flags.
- `lives_o`  out  $clog2(LIVES_INIT+1)  remaining lives.
- `level_o`  out  $clog2(LEVELS)  current level index, 0-based.
- `game_won_o`  out  1  valid in FINAL: 1 = won, 0 = lost.
- `countdown_o`  out  $clog2(max(CONTINUE_FRAMES,FINAL_FRAMES)+1)  frames remaining on the current timed screen; 0 otherwise.
- `restart_level_o`  out  1  one-cycle pulse that reinitialises level objects.

## Operation
- States: MENU, PLAYING, CONTINUE, FINAL. Exactly one `is_*_o` is high at all times, including the reset cycle.
- Start edge: `start_edge = start_btn_i & ~start_q`. `start_q` resets to 1, so a button held through reset does not register as a press.
- MENU, on `start_edge`:
  - Go to PLAYING.
  - lives ← LIVES_INIT, level ← 0, game_won ← 0.
  - Pulse `restart_level_o`.
- PLAYING:
  - `player_hit_i` with lives==1: lives ← 0, go to FINAL, game_won ← 0.
  - `player_hit_i` with lives>1: lives ← lives-1, go to CONTINUE.
  - `level_clear_i` with level==LEVELS-1: go to FINAL, game_won ← 1.
  - `level_clear_i` otherwise: level ← level+1, go to CONTINUE.
  - Both pulses in the same cycle: the hit wins and the clear is discarded.
  - `start_edge` is ignored.
- CONTINUE:
  - On entry, timer ← CONTINUE_FRAMES.
  - Each `frame_tick_i` decrements a non-zero timer.
  - Leave on the tick that takes the timer from 1 to 0, or earlier on `start_edge`.
  - Exit target is PLAYING with `restart_level_o` pulsed.
- FINAL:
  - On entry, timer ← FINAL_FRAMES.
  - Same decrement and early-exit rules as CONTINUE.
  - Exit target is MENU. lives and level hold their final values until the next start.
- `player_hit_i` and `level_clear_i` are ignored outside PLAYING.
- Timer is cleared to 0 on any entry to MENU or PLAYING.

## Timing
- Reset values: `is_menu_o`=1, other flags 0, `lives_o`=LIVES_INIT, `level_o`=0, `game_won_o`=0, `countdown_o`=0, `restart_level_o`=0, `start_q`=1.
- Latency: one cycle. An event sampled at edge N is visible on the outputs after edge N.
- `restart_level_o` is high exactly in the first cycle of each PLAYING entry.
- `countdown_o` reads the full duration (CONTINUE_FRAMES or FINAL_FRAMES) in the first cycle of the timed state.
- Timed screens last exactly N `frame_tick_i` pulses when no start press occurs.
- `frame_tick_i` coincident with `start_edge`: the start press exits; the result is identical either way.
- Reset asserted mid-game: MENU with reset values on the next edge, regardless of any pending events.

## Structure
- Shared package `game_pkg`:
  - `typedef enum logic [1:0] {ST_MENU, ST_PLAYING, ST_CONTINUE, ST_FINAL} game_state_e`.
  - Default frame-count constants, shared with the HUD and number-sprite blocks.
- Sub-module `rising_edge_detect`: one flop plus AND, with a reset-value parameter. Used for `start_btn_i` and reusable for other buttons.
- Remainder is one state register, lives/level/timer counters and registered decode of the phase flags.

## Test plan
- Reset with `start_btn_i` held at 1 → `is_menu_o`=1. Releasing and pressing again → PLAYING next cycle, `lives_o`=3, `level_o`=0, `restart_level_o` high for 1 cycle.
- In PLAYING with lives=3, pulse `player_hit_i` → CONTINUE, `lives_o`=2, `countdown_o`=180. After 180 `frame_tick_i` pulses → PLAYING with a restart pulse; after 179 pulses → still CONTINUE.
- Three hits, each continue screen skipped by a start press → third hit goes to FINAL, `game_won_o`=0, `lives_o`=0. After 300 ticks → MENU.
- `level_clear_i` four times with LEVELS=4 → `level_o` steps 0→1→2→3, then FINAL with `game_won_o`=1.
- `player_hit_i` and `level_clear_i` in the same cycle at level 1, lives 3 → CONTINUE, lives 2, level still 1. A pulse on either input during CONTINUE → no change.
- `rst_i` asserted during CONTINUE with `countdown_o`=50 → next cycle MENU, `countdown_o`=0, lives=3, level=0.
